knn_classificador: RTL and testbench

Hardware K-nearest-neighbour classifier that sits directly downstream of the Nios II "dados pronto" PIO. Software loads the training set into an on-chip RAM and drives the query point. It then raises the 1-bit data-ready PIO output, which this block consumes as its start request. The block scans all stored points, keeps the K smallest squared Euclidean distances, takes a majority vote over their labels, and presents the class and `done` on outputs read back through input PIOs.

---
 rtl/knn_classificador_if.sv | 46 ++++
 rtl/knn_classificador.sv | 253 +++++++++++++++++++++++++
 tb/tb_knn_classificador.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_classificador_if.sv
// ---------------------------------------------------------------------------
// knn_classificador_if
//
// Bundles every non-clock signal of the K-nearest-neighbour classifier:
//   host side    : dados_pronto (start/abort level), query_x/query_y,
//                  busy, done, class_out, dist_min
//   training RAM : mem_addr, mem_rd (read strobe), and mem_x, mem_y,
//                  mem_label (returned one cycle after mem_rd)
//
// master : the classifier itself
// slave  : the environment (PIO registers plus training RAM)
// ---------------------------------------------------------------------------
interface knn_classificador_if #(
  parameter int N_POINTS = 64,
  parameter int COORD_W  = 8,
  parameter int LABEL_W  = 4
);
  localparam int AW = $clog2(N_POINTS);
  localparam int DW = 2 * COORD_W + 1;

  // Host / PIO side
  logic               dados_pronto;
  logic [COORD_W-1:0] query_x;
  logic [COORD_W-1:0] query_y;
  logic               busy;
  logic               done;
  logic [LABEL_W-1:0] class_out;
  logic [DW-1:0]      dist_min;

  // Training RAM side
  logic [AW-1:0]      mem_addr;
  logic               mem_rd;
  logic [COORD_W-1:0] mem_x;
  logic [COORD_W-1:0] mem_y;
  logic [LABEL_W-1:0] mem_label;

  modport master (
    input  dados_pronto, query_x, query_y, mem_x, mem_y, mem_label,
    output busy, done, class_out, dist_min, mem_addr, mem_rd
  );

  modport slave (
    output dados_pronto, query_x, query_y, mem_x, mem_y, mem_label,
    input  busy, done, class_out, dist_min, mem_addr, mem_rd
  );
endinterface

// File: rtl/knn_classificador.sv
// ---------------------------------------------------------------------------
// knn_classificador
//
// Hardware K-nearest-neighbour classifier fed by the Nios II "dados pronto"
// PIO. On a start request it latches the query point, scans every training
// point in RAM (READ -> LATCH -> CALC -> INSERT, four cycles per point),
// keeps the K smallest squared Euclidean distances in an ascending list,
// then takes a majority vote over the labels of that list.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : knn_classificador_if.master
//            dados_pronto      start request (level); low mid-run aborts
//            query_x/query_y   query point, sampled only at start
//            mem_addr/mem_rd   training RAM read, one strobe per point
//            mem_x/mem_y/
//            mem_label         RAM data, valid the cycle after mem_rd
//            busy              scan or vote in progress
//            done              result valid, held until dados_pronto falls
//            class_out         voted class
//            dist_min          squared distance of the nearest point
// ---------------------------------------------------------------------------
module knn_classificador #(
  parameter int N_POINTS = 64,
  parameter int COORD_W  = 8,
  parameter int LABEL_W  = 4,
  parameter int K        = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  knn_classificador_if.master  bus
);

  localparam int AW = $clog2(N_POINTS);
  localparam int DW = 2 * COORD_W + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    CALC,
    INSERT,
    VOTE,
    DONE
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t             r_state;
  logic [COORD_W-1:0] r_qx;
  logic [COORD_W-1:0] r_qy;
  logic [AW-1:0]      r_idx;
  logic [COORD_W-1:0] r_px;
  logic [COORD_W-1:0] r_py;
  logic [LABEL_W-1:0] r_plab;
  logic [DW-1:0]      r_d;
  logic [LABEL_W-1:0] r_class;
  logic [DW-1:0]      r_dist_min;

  // Neighbour list, ascending by distance; slot 0 is the nearest.
  logic [DW-1:0]      r_dist [K];
  logic [LABEL_W-1:0] r_lab  [K];
  logic               r_val  [K];

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  state_t               w_next;
  logic                 w_busy;
  logic [COORD_W-1:0]   w_dx;
  logic [COORD_W-1:0]   w_dy;
  logic [2*COORD_W-1:0] w_dx2;
  logic [2*COORD_W-1:0] w_dy2;
  logic [DW-1:0]        w_d;
  logic [DW-1:0]        w_n_dist [K];
  logic [LABEL_W-1:0]   w_n_lab  [K];
  logic                 w_n_val  [K];
  logic [LABEL_W-1:0]   w_vote_lab;

  assign w_busy = (r_state == READ)   || (r_state == LATCH) ||
                  (r_state == CALC)   || (r_state == INSERT) ||
                  (r_state == VOTE);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.dados_pronto) w_next = READ;
      READ:    w_next = LATCH;
      LATCH:   w_next = CALC;
      CALC:    w_next = INSERT;
      INSERT:  w_next = (r_idx == LAST_IDX) ? VOTE : READ;
      VOTE:    w_next = DONE;
      DONE:    if (!bus.dados_pronto) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Dropping the request while working abandons the run at once.
    if (w_busy && !bus.dados_pronto) w_next = IDLE;
  end

  // -------------------------------------------------------------------------
  // Distance: |dx|^2 + |dy|^2 at full width, so (255,255) from (0,0)
  // gives 130050 rather than wrapping.
  // -------------------------------------------------------------------------
  assign w_dx  = (r_px >= r_qx) ? (r_px - r_qx) : (r_qx - r_px);
  assign w_dy  = (r_py >= r_qy) ? (r_py - r_qy) : (r_qy - r_py);
  assign w_dx2 = {{COORD_W{1'b0}}, w_dx} * {{COORD_W{1'b0}}, w_dx};
  assign w_dy2 = {{COORD_W{1'b0}}, w_dy} * {{COORD_W{1'b0}}, w_dy};
  assign w_d   = {1'b0, w_dx2} + {1'b0, w_dy2};

  // -------------------------------------------------------------------------
  // Sorted insert of r_d. Empty slots hold all-ones, which is larger than
  // any reachable distance, so they always accept. Strict less-than makes
  // an equal distance queue behind the existing entry (earlier index wins).
  // Because the list is sorted, lt[] is a run of zeros then ones: the first
  // set bit takes the new point, every later set bit shifts down by one,
  // and the old last entry falls off.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [K-1:0] lt;
    lt       = '0;
    w_n_dist = r_dist;
    w_n_lab  = r_lab;
    w_n_val  = r_val;
    for (int j = 0; j < K; j++) begin
      lt[j] = (r_d < r_dist[j]);
      if (lt[j]) begin
        w_n_dist[j] = r_d;
        w_n_lab[j]  = r_plab;
        w_n_val[j]  = 1'b1;
      end
    end
    for (int j = 1; j < K; j++) begin
      if (lt[j-1]) begin
        w_n_dist[j] = r_dist[j-1];
        w_n_lab[j]  = r_lab[j-1];
        w_n_val[j]  = r_val[j-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Majority vote. Walking the list nearest-first and replacing the winner
  // only on a strictly higher count means a tie goes to the label whose
  // best-ranked entry is nearest; all-distinct labels yield slot 0.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [2:0] cnt;
    logic [2:0] best_cnt;
    cnt        = '0;
    best_cnt   = '0;
    w_vote_lab = r_lab[0];
    for (int j = 0; j < K; j++) begin
      cnt = '0;
      for (int m = 0; m < K; m++) begin
        if (r_val[j] && r_val[m] && (r_lab[m] == r_lab[j])) cnt = cnt + 3'd1;
      end
      if (cnt > best_cnt) begin
        best_cnt   = cnt;
        w_vote_lab = r_lab[j];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the neighbour list is reset along with the rest: it is a handful
  // of flops, not a RAM, and must read as empty straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_qx       <= '0;
      r_qy       <= '0;
      r_idx      <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_plab     <= '0;
      r_d        <= '0;
      r_class    <= '0;
      r_dist_min <= '0;
      for (int j = 0; j < K; j++) begin
        r_dist[j] <= '1;
        r_lab[j]  <= '0;
        r_val[j]  <= 1'b0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.dados_pronto) begin
            r_qx  <= bus.query_x;
            r_qy  <= bus.query_y;
            r_idx <= '0;
            for (int j = 0; j < K; j++) begin
              r_dist[j] <= '1;
              r_lab[j]  <= '0;
              r_val[j]  <= 1'b0;
            end
          end
        end
        LATCH: begin
          r_px   <= bus.mem_x;
          r_py   <= bus.mem_y;
          r_plab <= bus.mem_label;
        end
        CALC: r_d <= w_d;
        INSERT: begin
          if (bus.dados_pronto) begin
            r_dist <= w_n_dist;
            r_lab  <= w_n_lab;
            r_val  <= w_n_val;
            if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
          end
        end
        VOTE: begin
          // An abort in this cycle must leave the previous result intact.
          if (bus.dados_pronto) begin
            r_class    <= w_vote_lab;
            r_dist_min <= r_dist[0];
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.mem_rd    = (r_state == READ);
  assign bus.mem_addr  = r_idx;
  assign bus.busy      = w_busy;
  assign bus.done      = (r_state == DONE);
  assign bus.class_out = r_class;
  assign bus.dist_min  = r_dist_min;

endmodule

// File: tb/tb_knn_classificador.sv
// ---------------------------------------------------------------------------
// tb_knn_classificador
//
// Two classifier instances share clock and reset: u_dut_a (4 points, K=3)
// and u_dut_b (4 points, K=1). Each has a small training RAM model with one
// cycle of read latency. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so a value seen after the k-th
// edge following the start cycle c belongs to cycle c+k.
// ---------------------------------------------------------------------------
module tb_knn_classificador;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int LW = 4;
  localparam int AW = 2;
  localparam int DW = 17;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  knn_classificador_if #(.N_POINTS(N), .COORD_W(CW), .LABEL_W(LW)) ifa ();
  knn_classificador_if #(.N_POINTS(N), .COORD_W(CW), .LABEL_W(LW)) ifb ();

  knn_classificador #(.N_POINTS(N), .COORD_W(CW), .LABEL_W(LW), .K(3)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  knn_classificador #(.N_POINTS(N), .COORD_W(CW), .LABEL_W(LW), .K(1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  // Training RAMs
  logic [CW-1:0] ra_x [N];
  logic [CW-1:0] ra_y [N];
  logic [LW-1:0] ra_l [N];
  logic [CW-1:0] rb_x [N];
  logic [CW-1:0] rb_y [N];
  logic [LW-1:0] rb_l [N];

  always @(posedge clk) begin
    if (ifa.mem_rd) begin
      ifa.mem_x     <= ra_x[ifa.mem_addr];
      ifa.mem_y     <= ra_y[ifa.mem_addr];
      ifa.mem_label <= ra_l[ifa.mem_addr];
    end
    if (ifb.mem_rd) begin
      ifb.mem_x     <= rb_x[ifb.mem_addr];
      ifb.mem_y     <= rb_y[ifb.mem_addr];
      ifb.mem_label <= rb_l[ifb.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done on the selected instance; cyc = edges waited,
  // or -1 if done never rose.
  task automatic wait_done(input bit sel_b, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if ((sel_b ? ifb.done : ifa.done) === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic load_basic_a();
    ra_x = '{8'd10, 8'd0, 8'd11, 8'd13};
    ra_y = '{8'd12, 8'd0, 8'd10, 8'd14};
    ra_l = '{4'd1,  4'd2, 4'd2,  4'd2};
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    ifa.dados_pronto = 1'b0;
    ifb.dados_pronto = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (ifa.busy !== 1'b0)     begin n_errors++; $display("FAIL reset_busy got=%b want=0", ifa.busy); end
    n_checks++; if (ifa.done !== 1'b0)     begin n_errors++; $display("FAIL reset_done got=%b want=0", ifa.done); end
    n_checks++; if (ifa.mem_rd !== 1'b0)   begin n_errors++; $display("FAIL reset_mem_rd got=%b want=0", ifa.mem_rd); end
    n_checks++; if (ifa.mem_addr !== 2'd0) begin n_errors++; $display("FAIL reset_mem_addr got=%0d want=0", ifa.mem_addr); end
    n_checks++; if (ifa.class_out !== 4'd0) begin n_errors++; $display("FAIL reset_class got=%0d want=0", ifa.class_out); end
    n_checks++; if (ifa.dist_min !== 17'd0) begin n_errors++; $display("FAIL reset_dist got=%0d want=0", ifa.dist_min); end
    n_checks++; if ({ifb.busy, ifb.done, ifb.mem_rd} !== 3'b000) begin n_errors++; $display("FAIL reset_b_ctrl got=%b want=000", {ifb.busy, ifb.done, ifb.mem_rd}); end
  endtask

  // -------------------------------------------------------------------------
  // Query (10,10): distances 4(L1), 200(L2), 1(L2), 25(L2). Kept: 1,4,25
  // with labels 2,1,2 -> class 2, dist_min 1. Cycle-exact timing checks.
  task automatic test_basic();
    logic exp_busy, exp_done, exp_rd;
    logic [AW-1:0] exp_addr;
    load_basic_a();
    ifa.query_x = 8'd10;
    ifa.query_y = 8'd10;
    ifa.dados_pronto = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_busy = (k <= 17);
      exp_done = (k == 18);
      exp_rd   = (k == 1) || (k == 5) || (k == 9) || (k == 13);
      exp_addr = AW'((k - 1) / 4);
      n_checks++; if (ifa.busy !== exp_busy) begin n_errors++; $display("FAIL basic_busy c+%0d got=%b want=%b", k, ifa.busy, exp_busy); end
      n_checks++; if (ifa.done !== exp_done) begin n_errors++; $display("FAIL basic_done c+%0d got=%b want=%b", k, ifa.done, exp_done); end
      n_checks++; if (ifa.mem_rd !== exp_rd) begin n_errors++; $display("FAIL basic_mem_rd c+%0d got=%b want=%b", k, ifa.mem_rd, exp_rd); end
      if (exp_rd) begin
        n_checks++; if (ifa.mem_addr !== exp_addr) begin n_errors++; $display("FAIL basic_mem_addr c+%0d got=%0d want=%0d", k, ifa.mem_addr, exp_addr); end
      end
    end
    n_checks++; if (ifa.class_out !== 4'd2) begin n_errors++; $display("FAIL basic_class got=%0d want=2", ifa.class_out); end
    n_checks++; if (ifa.dist_min !== 17'd1) begin n_errors++; $display("FAIL basic_dist got=%0d want=1", ifa.dist_min); end
    ifa.dados_pronto = 1'b0;
    tick();
    n_checks++; if (ifa.done !== 1'b0) begin n_errors++; $display("FAIL basic_done_clear got=%b want=0", ifa.done); end
  endtask

  // -------------------------------------------------------------------------
  // Query (20,20): d=18(L9), 800(L1), 2(L5), 8(L7). Kept 2,8,18 with
  // distinct labels 5,7,9 -> class 5, dist_min 2.
  task automatic test_distinct_tie();
    int cyc;
    ra_x = '{8'd23, 8'd40, 8'd21, 8'd22};
    ra_y = '{8'd23, 8'd40, 8'd21, 8'd22};
    ra_l = '{4'd9,  4'd1,  4'd5,  4'd7};
    ifa.query_x = 8'd20;
    ifa.query_y = 8'd20;
    ifa.dados_pronto = 1'b1;
    wait_done(1'b0, cyc);
    n_checks++; if (cyc !== 18) begin n_errors++; $display("FAIL tie_latency got=%0d want=18", cyc); end
    n_checks++; if (ifa.class_out !== 4'd5) begin n_errors++; $display("FAIL tie_class got=%0d want=5", ifa.class_out); end
    n_checks++; if (ifa.dist_min !== 17'd2) begin n_errors++; $display("FAIL tie_dist got=%0d want=2", ifa.dist_min); end
    ifa.dados_pronto = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  // K=1, query (5,5): d=9(L3), 50(L1), 9(L4), 32(L2) -> earlier index, L3.
  task automatic test_equal_dist();
    int cyc;
    rb_x = '{8'd8, 8'd0, 8'd5, 8'd9};
    rb_y = '{8'd5, 8'd0, 8'd8, 8'd9};
    rb_l = '{4'd3, 4'd1, 4'd4, 4'd2};
    ifb.query_x = 8'd5;
    ifb.query_y = 8'd5;
    ifb.dados_pronto = 1'b1;
    wait_done(1'b1, cyc);
    n_checks++; if (cyc !== 18) begin n_errors++; $display("FAIL equal_latency got=%0d want=18", cyc); end
    n_checks++; if (ifb.class_out !== 4'd3) begin n_errors++; $display("FAIL equal_class got=%0d want=3", ifb.class_out); end
    n_checks++; if (ifb.dist_min !== 17'd9) begin n_errors++; $display("FAIL equal_dist got=%0d want=9", ifb.dist_min); end
    ifb.dados_pronto = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Query (0,0), all points at (255,255) label 6: 2*255^2 = 130050.
  // The query inputs move to (255,255) after the start; that must not
  // matter (otherwise the distance would be 0).
  task automatic test_extremes();
    int cyc;
    ra_x = '{8'd255, 8'd255, 8'd255, 8'd255};
    ra_y = '{8'd255, 8'd255, 8'd255, 8'd255};
    ra_l = '{4'd6,   4'd6,   4'd6,   4'd6};
    ifa.query_x = 8'd0;
    ifa.query_y = 8'd0;
    ifa.dados_pronto = 1'b1;
    tick();
    ifa.query_x = 8'd255;
    ifa.query_y = 8'd255;
    wait_done(1'b0, cyc);
    n_checks++; if (cyc !== 17) begin n_errors++; $display("FAIL ext_latency got=%0d want=17", cyc); end
    n_checks++; if (ifa.dist_min !== 17'd130050) begin n_errors++; $display("FAIL ext_dist got=%0d want=130050", ifa.dist_min); end
    n_checks++; if (ifa.class_out !== 4'd6) begin n_errors++; $display("FAIL ext_class got=%0d want=6", ifa.class_out); end
    ifa.dados_pronto = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Drop the request at c+7; previous result (6, 130050) must survive.
  task automatic test_abort();
    int  cyc;
    bit  saw_done, saw_rd;
    load_basic_a();
    ifa.query_x = 8'd10;
    ifa.query_y = 8'd10;
    ifa.dados_pronto = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) begin
        n_checks++; if ({ifa.mem_rd, ifa.mem_addr} !== {1'b1, 2'd1}) begin n_errors++; $display("FAIL abort_pre_read got=%b/%0d want=1/1", ifa.mem_rd, ifa.mem_addr); end
      end
    end
    ifa.dados_pronto = 1'b0;
    tick();
    n_checks++; if (ifa.busy !== 1'b0)   begin n_errors++; $display("FAIL abort_busy got=%b want=0", ifa.busy); end
    n_checks++; if (ifa.mem_rd !== 1'b0) begin n_errors++; $display("FAIL abort_mem_rd got=%b want=0", ifa.mem_rd); end
    saw_done = 1'b0;
    saw_rd   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ifa.done !== 1'b0)   saw_done = 1'b1;
      if (ifa.mem_rd !== 1'b0) saw_rd   = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_errors++; $display("FAIL abort_done_raised got=1 want=0"); end
    n_checks++; if (saw_rd !== 1'b0)   begin n_errors++; $display("FAIL abort_late_read got=1 want=0"); end
    n_checks++; if (ifa.class_out !== 4'd6) begin n_errors++; $display("FAIL abort_class_kept got=%0d want=6", ifa.class_out); end
    n_checks++; if (ifa.dist_min !== 17'd130050) begin n_errors++; $display("FAIL abort_dist_kept got=%0d want=130050", ifa.dist_min); end
    // Restart from address 0
    ifa.dados_pronto = 1'b1;
    tick();
    n_checks++; if ({ifa.busy, ifa.mem_rd, ifa.mem_addr} !== {1'b1, 1'b1, 2'd0}) begin n_errors++; $display("FAIL abort_restart got=%b%b/%0d want=11/0", ifa.busy, ifa.mem_rd, ifa.mem_addr); end
    wait_done(1'b0, cyc);
    n_checks++; if (cyc !== 17) begin n_errors++; $display("FAIL abort_restart_latency got=%0d want=17", cyc); end
    n_checks++; if (ifa.class_out !== 4'd2) begin n_errors++; $display("FAIL abort_restart_class got=%0d want=2", ifa.class_out); end
    n_checks++; if (ifa.dist_min !== 17'd1) begin n_errors++; $display("FAIL abort_restart_dist got=%0d want=1", ifa.dist_min); end
    ifa.dados_pronto = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Reset at c+6 mid-scan: everything back to reset values at c+7.
  task automatic test_reset_midscan();
    load_basic_a();
    ifa.dados_pronto = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    reset = 1'b1;
    ifa.dados_pronto = 1'b0;
    tick();
    n_checks++; if ({ifa.busy, ifa.done, ifa.mem_rd} !== 3'b000) begin n_errors++; $display("FAIL rstmid_ctrl got=%b want=000", {ifa.busy, ifa.done, ifa.mem_rd}); end
    n_checks++; if (ifa.mem_addr !== 2'd0)  begin n_errors++; $display("FAIL rstmid_addr got=%0d want=0", ifa.mem_addr); end
    n_checks++; if (ifa.class_out !== 4'd0) begin n_errors++; $display("FAIL rstmid_class got=%0d want=0", ifa.class_out); end
    n_checks++; if (ifa.dist_min !== 17'd0) begin n_errors++; $display("FAIL rstmid_dist got=%0d want=0", ifa.dist_min); end
    reset = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Holding the request high through DONE gives no second run; low then
  // high gives exactly one more.
  task automatic test_back_to_back();
    int cyc;
    bit lost_done, saw_busy, saw_rd;
    load_basic_a();
    ifa.query_x = 8'd10;
    ifa.query_y = 8'd10;
    ifa.dados_pronto = 1'b1;
    wait_done(1'b0, cyc);
    n_checks++; if (cyc !== 18) begin n_errors++; $display("FAIL b2b_first_latency got=%0d want=18", cyc); end
    lost_done = 1'b0;
    saw_busy  = 1'b0;
    saw_rd    = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ifa.done !== 1'b1)   lost_done = 1'b1;
      if (ifa.busy !== 1'b0)   saw_busy  = 1'b1;
      if (ifa.mem_rd !== 1'b0) saw_rd    = 1'b1;
    end
    n_checks++; if (lost_done !== 1'b0) begin n_errors++; $display("FAIL b2b_done_held got=dropped want=held"); end
    n_checks++; if ({saw_busy, saw_rd} !== 2'b00) begin n_errors++; $display("FAIL b2b_second_run got=%b want=00", {saw_busy, saw_rd}); end
    ifa.dados_pronto = 1'b0;
    tick();
    n_checks++; if (ifa.done !== 1'b0) begin n_errors++; $display("FAIL b2b_done_clear got=%b want=0", ifa.done); end
    ifa.dados_pronto = 1'b1;
    wait_done(1'b0, cyc);
    n_checks++; if (cyc !== 18) begin n_errors++; $display("FAIL b2b_second_latency got=%0d want=18", cyc); end
    n_checks++; if (ifa.class_out !== 4'd2) begin n_errors++; $display("FAIL b2b_class got=%0d want=2", ifa.class_out); end
    ifa.dados_pronto = 1'b0;
    tick();
    n_checks++; if ({ifa.done, ifa.busy} !== 2'b00) begin n_errors++; $display("FAIL b2b_idle got=%b want=00", {ifa.done, ifa.busy}); end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    ifa.dados_pronto = 1'b0;
    ifa.query_x = '0;
    ifa.query_y = '0;
    ifb.dados_pronto = 1'b0;
    ifb.query_x = '0;
    ifb.query_y = '0;
    test_reset();
    test_basic();
    test_distinct_tie();
    test_equal_dist();
    test_extremes();
    test_abort();
    test_reset_midscan();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "simulation did not finish");
  end

endmodule
